load_store_unit: RTL and testbench
==================================

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 SHALL have parameter MEM_BYTES, default 128, meaning the data-memory size in bytes; legal addresses are 0..MEM_BYTES-1.
REQ-002 SHALL have port clk_i, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst_i, input, 1 bit: reset, asynchronous, active-low.
REQ-004 SHALL have port req_valid_i, input, 1 bit: CPU request valid.
REQ-005 SHALL have port req_ready_o, output, 1 bit: unit can accept a request.
REQ-006 SHALL have port req_write_i, input, 1 bit: 1 = store, 0 = load.
REQ-007 SHALL have port req_size_i, input, 2 bits: 00 byte, 01 half, 10 word, 11 illegal.
REQ-008 SHALL have port req_unsigned_i, input, 1 bit: load zero-extends when 1, sign-extends when 0.
REQ-009 SHALL have port req_addr_i, input, 32 bits: byte address.
REQ-010 SHALL have port req_wdata_i, input, 32 bits: store data, right-justified.
REQ-011 SHALL have port rsp_valid_o, output, 1 bit: one-cycle completion pulse.
REQ-012 SHALL have port rsp_rdata_o, output, 32 bits: extended load data; 0 for stores and errors.
REQ-013 SHALL have port rsp_err_o, output, 1 bit: access rejected; qualified by rsp_valid_o.
REQ-014 SHALL have port mem_addr_o, output, 32 bits: word-aligned address driven to the data memory.
REQ-015 SHALL have port mem_data_o, output, 32 bits: write word driven to the data memory.
REQ-016 SHALL have port mem_read_o, output, 1 bit: memory read enable.
REQ-017 SHALL have port mem_write_o, output, 1 bit: memory write enable; memory writes on the clock edge ending the cycle.
REQ-018 SHALL have port mem_data_i, input, 32 bits: combinational read word from the memory, little-endian byte order.

Function
REQ-019 SHALL implement the states IDLE, READ, WRITE and RESP.
REQ-020 SHALL assert req_ready_o only in IDLE; a request is accepted on an edge where req_valid_i=1 and req_ready_o=1, and all request fields are registered at that edge.
REQ-021 SHALL classify as an error: size 11; half-word with addr[0]=1; word with addr[1:0]!=0; any addr+size_bytes>MEM_BYTES.
REQ-022 SHALL route an accepted error request IDLE->RESP with rsp_err_o=1 and no memory enable asserted.
REQ-023 SHALL route loads IDLE->READ->RESP.
REQ-024 SHALL route word stores IDLE->WRITE->RESP.
REQ-025 SHALL route byte and half stores IDLE->READ->WRITE->RESP (read-modify-write).
REQ-026 In READ, SHALL drive mem_read_o=1 and mem_addr_o={addr[31:2],2'b00}, and capture mem_data_i at the edge leaving READ.
REQ-027 In WRITE, SHALL drive mem_write_o=1 for exactly one cycle at the aligned address; mem_data_o is req_wdata_i for word stores, otherwise the captured word with only the addressed byte or half-word lanes replaced.
REQ-028 Outside READ and WRITE, SHALL hold mem_read_o, mem_write_o, mem_addr_o and mem_data_o at 0.
REQ-029 In RESP, SHALL assert rsp_valid_o for exactly one cycle and then return to IDLE; there is no response back-pressure.
REQ-030 rsp_rdata_o SHALL be the byte or half selected by addr[1:0], extended to 32 bits per req_unsigned_i; word loads are passed unchanged.
REQ-031 Latency from the accept edge to rsp_valid_o high SHALL be: error 1 cycle; load or word store 2 cycles; sub-word store 3 cycles.
REQ-032 A request held valid during RESP SHALL be accepted in the following IDLE cycle; the sustained rate is therefore one request per (latency+1) cycles.

Reset
REQ-033 While rst_i=0, SHALL force state IDLE, all registered request fields to 0, rsp_valid_o, rsp_err_o, rsp_rdata_o and all mem_* outputs to 0, and req_ready_o=1.
REQ-034 A reset asserted mid-operation SHALL drop mem_write_o immediately, so no partial write reaches memory after the asynchronous assertion, and no response for the aborted request is issued.

Structure
REQ-035 SHALL place in package lsu_pkg: the size encodings (SZ_BYTE, SZ_HALF, SZ_WORD), the state enum type, and the lane-merge/extract functions.
REQ-036 SHALL contain one combinational sub-module, lsu_lane_align, performing byte-lane merge for stores and extract/extend for loads; the FSM stays in load_store_unit.

Verification (bench instantiates the team data memory, MEM_BYTES=128, initialised to 0)
REQ-037 Word store 0xDEADBEEF to 0x10, then word load 0x10 -> one mem_write_o pulse; store rsp at +2 cycles; load rsp_rdata_o=0xDEADBEEF at +2, err=0.
REQ-038 Byte store 0x5A to 0x13 over 0xDEADBEEF -> READ then WRITE with mem_data_o=0x5AADBEEF, rsp at +3; signed byte load 0x12 -> 0xFFFFFFAD; unsigned byte load 0x12 -> 0x000000AD; signed half load 0x12 -> 0x00005AAD.
REQ-039 Half store to 0x11, word load from 0x80 and size 11 -> rsp_err_o=1 at +1, mem_read_o=mem_write_o=0 throughout, memory unchanged.
REQ-040 rst_i pulled low during READ of a half store to 0x20 -> no mem_write_o pulse, no rsp_valid_o, word 0x20 unchanged, req_ready_o=1 after release.
REQ-041 req_valid_i held high with two queued loads -> second accepted in the first IDLE cycle after RESP; exactly one rsp_valid_o pulse per request, in order.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: access-size codes, FSM state
// type and the byte-lane helpers used for store merging and load extraction.
package lsu_pkg;

    localparam logic [1:0] SZ_BYTE    = 2'b00;
    localparam logic [1:0] SZ_HALF    = 2'b01;
    localparam logic [1:0] SZ_WORD    = 2'b10;
    localparam logic [1:0] SZ_ILLEGAL = 2'b11;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2,
        RESP  = 2'd3
    } lsu_state_e;

    // Number of bytes touched by an access; 0 for the illegal encoding.
    function automatic logic [2:0] size_bytes(input logic [1:0] size);
        logic [2:0] n;
        case (size)
            SZ_BYTE: n = 3'd1;
            SZ_HALF: n = 3'd2;
            SZ_WORD: n = 3'd4;
            default: n = 3'd0;
        endcase
        return n;
    endfunction

    // Replace only the addressed lanes of the old word with right-justified store data.
    function automatic logic [31:0] lane_merge(input logic [31:0] old_word,
                                               input logic [31:0] wdata,
                                               input logic [1:0]  offset,
                                               input logic [1:0]  size);
        logic [31:0] w;
        w = old_word;
        case (size)
            SZ_BYTE: w[{offset, 3'b000} +: 8]       = wdata[7:0];
            SZ_HALF: w[{offset[1], 4'b0000} +: 16]  = wdata[15:0];
            SZ_WORD: w = wdata;
            default: w = old_word;
        endcase
        return w;
    endfunction

    // Select the addressed byte/half and extend it to 32 bits; words pass through.
    function automatic logic [31:0] lane_extract(input logic [31:0] word,
                                                 input logic [1:0]  offset,
                                                 input logic [1:0]  size,
                                                 input logic        is_unsigned);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        b = word[{offset, 3'b000} +: 8];
        h = word[{offset[1], 4'b0000} +: 16];
        case (size)
            SZ_BYTE: r = is_unsigned ? {24'h000000, b} : {{24{b[7]}}, b};
            SZ_HALF: r = is_unsigned ? {16'h0000, h} : {{16{h[15]}}, h};
            SZ_WORD: r = word;
            default: r = 32'h0000_0000;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Combinational byte-lane datapath: merges store data into a read word and
// extracts/extends load data from a read word.
module lsu_lane_align
    import lsu_pkg::*;
(
    input  logic [31:0] rd_word,
    input  logic [31:0] wdata,
    input  logic [1:0]  offset,
    input  logic [1:0]  size,
    input  logic        is_unsigned,
    output logic [31:0] merged,
    output logic [31:0] load_data
);

    // Lane merge for read-modify-write stores and lane extract for loads.
    always_comb begin
        merged    = lane_merge(rd_word, wdata, offset, size);
        load_data = lane_extract(rd_word, offset, size, is_unsigned);
    end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: accepts one CPU request at a time, validates it, performs
// the memory read and/or write it needs and returns a one-cycle response.
// All outputs come straight from flops, loaded with the values that belong to
// the state being entered.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int MEM_BYTES = 128
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic        req_write_i,
    input  logic [1:0]  req_size_i,
    input  logic        req_unsigned_i,
    input  logic [31:0] req_addr_i,
    input  logic [31:0] req_wdata_i,
    output logic        rsp_valid_o,
    output logic [31:0] rsp_rdata_o,
    output logic        rsp_err_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_data_o,
    output logic        mem_read_o,
    output logic        mem_write_o,
    input  logic [31:0] mem_data_i
);

    lsu_state_e  state_r, state_s;
    logic        write_r, unsigned_r;
    logic [1:0]  size_r;
    logic [31:0] addr_r, wdata_r;

    logic        accept_s, err_s, misalign_s;
    logic [32:0] end_addr_s;
    logic [31:0] merged_s, load_data_s;

    logic        ready_s, rsp_valid_s, rsp_err_s, mem_read_s, mem_write_s;
    logic [31:0] rsp_rdata_s, mem_addr_s, mem_data_s;
    logic        ready_r, rsp_valid_r, rsp_err_r, mem_read_r, mem_write_r;
    logic [31:0] rsp_rdata_r, mem_addr_r, mem_data_r;

    assign accept_s    = req_valid_i && ready_r;
    assign req_ready_o = ready_r;
    assign rsp_valid_o = rsp_valid_r;
    assign rsp_err_o   = rsp_err_r;
    assign rsp_rdata_o = rsp_rdata_r;
    assign mem_read_o  = mem_read_r;
    assign mem_write_o = mem_write_r;
    assign mem_addr_o  = mem_addr_r;
    assign mem_data_o  = mem_data_r;

    lsu_lane_align u_align (
        .rd_word     (mem_data_i),
        .wdata       (wdata_r),
        .offset      (addr_r[1:0]),
        .size        (size_r),
        .is_unsigned (unsigned_r),
        .merged      (merged_s),
        .load_data   (load_data_s)
    );

    // Classify the incoming request (alignment and range) before it is accepted.
    always_comb begin
        end_addr_s = {1'b0, req_addr_i} + {30'd0, size_bytes(req_size_i)};
        case (req_size_i)
            SZ_BYTE: misalign_s = 1'b0;
            SZ_HALF: misalign_s = req_addr_i[0];
            SZ_WORD: misalign_s = (req_addr_i[1:0] != 2'b00);
            default: misalign_s = 1'b1;
        endcase
        err_s = misalign_s || (end_addr_s > 33'(MEM_BYTES));
    end

    // State register.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state logic: errors skip memory, sub-word stores read first.
    always_comb begin
        state_s = IDLE;
        case (state_r)
            IDLE: begin
                if (!req_valid_i) begin
                    state_s = IDLE;
                end else if (err_s) begin
                    state_s = RESP;
                end else if (req_write_i && (req_size_i == SZ_WORD)) begin
                    state_s = WRITE;
                end else begin
                    state_s = READ;
                end
            end
            READ:    state_s = write_r ? WRITE : RESP;
            WRITE:   state_s = RESP;
            RESP:    state_s = IDLE;
            default: state_s = IDLE;
        endcase
    end

    // Output values for the state being entered; the entry path selects the data source.
    always_comb begin
        ready_s     = 1'b0;
        rsp_valid_s = 1'b0;
        rsp_err_s   = 1'b0;
        rsp_rdata_s = 32'h0000_0000;
        mem_read_s  = 1'b0;
        mem_write_s = 1'b0;
        mem_addr_s  = 32'h0000_0000;
        mem_data_s  = 32'h0000_0000;
        case (state_s)
            IDLE: ready_s = 1'b1;
            READ: begin
                mem_read_s = 1'b1;
                if (state_r == IDLE) begin
                    mem_addr_s = {req_addr_i[31:2], 2'b00};
                end else begin
                    mem_addr_s = {addr_r[31:2], 2'b00};
                end
            end
            WRITE: begin
                mem_write_s = 1'b1;
                if (state_r == IDLE) begin
                    mem_addr_s = {req_addr_i[31:2], 2'b00};
                    mem_data_s = req_wdata_i;
                end else begin
                    mem_addr_s = {addr_r[31:2], 2'b00};
                    mem_data_s = merged_s;
                end
            end
            RESP: begin
                rsp_valid_s = 1'b1;
                if (state_r == IDLE) begin
                    rsp_err_s = 1'b1;
                end else if (state_r == READ) begin
                    rsp_rdata_s = load_data_s;
                end else begin
                    rsp_rdata_s = 32'h0000_0000;
                end
            end
            default: ready_s = 1'b0;
        endcase
    end

    // Output flops; asynchronous reset kills any pending memory write at once.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            ready_r     <= 1'b1;
            rsp_valid_r <= 1'b0;
            rsp_err_r   <= 1'b0;
            rsp_rdata_r <= 32'h0000_0000;
            mem_read_r  <= 1'b0;
            mem_write_r <= 1'b0;
            mem_addr_r  <= 32'h0000_0000;
            mem_data_r  <= 32'h0000_0000;
        end else begin
            ready_r     <= ready_s;
            rsp_valid_r <= rsp_valid_s;
            rsp_err_r   <= rsp_err_s;
            rsp_rdata_r <= rsp_rdata_s;
            mem_read_r  <= mem_read_s;
            mem_write_r <= mem_write_s;
            mem_addr_r  <= mem_addr_s;
            mem_data_r  <= mem_data_s;
        end
    end

    // Capture all request fields at the accept edge.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            write_r    <= 1'b0;
            size_r     <= 2'b00;
            unsigned_r <= 1'b0;
            addr_r     <= 32'h0000_0000;
            wdata_r    <= 32'h0000_0000;
        end else if (accept_s) begin
            write_r    <= req_write_i;
            size_r     <= req_size_i;
            unsigned_r <= req_unsigned_i;
            addr_r     <= req_addr_i;
            wdata_r    <= req_wdata_i;
        end else begin
            write_r    <= write_r;
            size_r     <= size_r;
            unsigned_r <= unsigned_r;
            addr_r     <= addr_r;
            wdata_r    <= wdata_r;
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit: a byte-array reference model predicts
// responses and memory traffic; a negedge monitor compares what the DUT does.
module tb_load_store_unit;

    localparam int MEM_BYTES = 128;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b0;
    logic        req_valid_i = 1'b0;
    logic        req_ready_o;
    logic        req_write_i = 1'b0;
    logic [1:0]  req_size_i = 2'b00;
    logic        req_unsigned_i = 1'b0;
    logic [31:0] req_addr_i = 32'h0;
    logic [31:0] req_wdata_i = 32'h0;
    logic        rsp_valid_o;
    logic [31:0] rsp_rdata_o;
    logic        rsp_err_o;
    logic [31:0] mem_addr_o;
    logic [31:0] mem_data_o;
    logic        mem_read_o;
    logic        mem_write_o;
    logic [31:0] mem_data_i;

    load_store_unit #(.MEM_BYTES(MEM_BYTES)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
        .req_write_i(req_write_i), .req_size_i(req_size_i),
        .req_unsigned_i(req_unsigned_i), .req_addr_i(req_addr_i),
        .req_wdata_i(req_wdata_i), .rsp_valid_o(rsp_valid_o),
        .rsp_rdata_o(rsp_rdata_o), .rsp_err_o(rsp_err_o),
        .mem_addr_o(mem_addr_o), .mem_data_o(mem_data_o),
        .mem_read_o(mem_read_o), .mem_write_o(mem_write_o),
        .mem_data_i(mem_data_i)
    );

    always #5 clk_i = ~clk_i;

    int cyc = 0;
    always @(posedge clk_i) cyc <= cyc + 1;

    int checks = 0;
    int failures = 0;

    // Data memory: combinational little-endian read, write at the clock edge.
    logic [7:0] dmem    [0:MEM_BYTES-1] = '{default: 8'h00};
    logic [7:0] ref_mem [0:MEM_BYTES-1] = '{default: 8'h00};

    always_comb begin
        if (mem_addr_o < 32'd128)
            mem_data_i = {dmem[{mem_addr_o[6:2], 2'd3}], dmem[{mem_addr_o[6:2], 2'd2}],
                          dmem[{mem_addr_o[6:2], 2'd1}], dmem[{mem_addr_o[6:2], 2'd0}]};
        else
            mem_data_i = 32'h0;
    end

    always @(posedge clk_i) begin
        if (mem_write_o && mem_addr_o < 32'd128) begin
            dmem[{mem_addr_o[6:2], 2'd0}] <= mem_data_o[7:0];
            dmem[{mem_addr_o[6:2], 2'd1}] <= mem_data_o[15:8];
            dmem[{mem_addr_o[6:2], 2'd2}] <= mem_data_o[23:16];
            dmem[{mem_addr_o[6:2], 2'd3}] <= mem_data_o[31:24];
        end
    end

    typedef struct { logic err; logic [31:0] rdata; int acc; int lat; } rsp_t;
    typedef struct { logic [31:0] addr; logic [31:0] data; } wr_t;
    rsp_t        rsp_q[$];
    wr_t         wr_q[$];
    logic [31:0] rd_q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%08h expected=0x%08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        failures++;
        $display("FAIL %s (t=%0t)", name, $time);
    endtask

    function automatic logic [31:0] ref_word(input int base);
        return {ref_mem[base+3], ref_mem[base+2], ref_mem[base+1], ref_mem[base]};
    endfunction

    // Reference model: predicts response, latency and memory traffic of one request.
    task automatic model(input logic w, input logic [1:0] sz, input logic u,
                         input logic [31:0] a, input logic [31:0] d, input int acc);
        int n;
        int base;
        longint end_a;
        logic err;
        logic [31:0] v;
        n = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : (sz == 2'd2) ? 4 : 0;
        end_a = longint'(a) + longint'(n);
        err = (sz == 2'd3) || (sz == 2'd1 && a % 2 != 0) || (sz == 2'd2 && a % 4 != 0)
              || end_a > longint'(MEM_BYTES);
        if (err) begin
            rsp_q.push_back('{err: 1'b1, rdata: 32'h0, acc: acc, lat: 1});
        end else begin
            base = int'(a) - int'(a) % 4;
            if (!w) begin
                rd_q.push_back(32'(base));
                v = 32'h0;
                for (int i = 0; i < n; i++) v = v | (32'(ref_mem[int'(a) + i]) << (8 * i));
                if (!u && n == 1) v = {{24{v[7]}}, v[7:0]};
                if (!u && n == 2) v = {{16{v[15]}}, v[15:0]};
                rsp_q.push_back('{err: 1'b0, rdata: v, acc: acc, lat: 2});
            end else begin
                for (int i = 0; i < n; i++) ref_mem[int'(a) + i] = 8'((d >> (8 * i)) & 32'hFF);
                if (n != 4) rd_q.push_back(32'(base));
                wr_q.push_back('{addr: 32'(base), data: ref_word(base)});
                rsp_q.push_back('{err: 1'b0, rdata: 32'h0, acc: acc, lat: (n == 4) ? 2 : 3});
            end
        end
    endtask

    // Drive one request starting at a negedge; returns at the negedge after acceptance.
    task automatic issue(input logic w, input logic [1:0] sz, input logic u,
                         input logic [31:0] a, input logic [31:0] d,
                         input bit do_model, input bit hold, output int acc);
        req_write_i = w; req_size_i = sz; req_unsigned_i = u;
        req_addr_i = a;  req_wdata_i = d; req_valid_i = 1'b1;
        acc = -1;
        for (int k = 0; k < 20 && !req_ready_o; k++) @(negedge clk_i);
        if (!req_ready_o) begin
            fail_now("accept_timeout");
            req_valid_i = 1'b0;
        end else begin
            acc = cyc + 1;
            if (do_model) model(w, sz, u, a, d, acc);
            @(negedge clk_i);
            if (!hold) req_valid_i = 1'b0;
        end
    endtask

    // Monitor: compares memory traffic and responses against the scoreboard queues.
    always @(negedge clk_i) begin
        if (rst_i) begin
            if (mem_read_o && mem_write_o) fail_now("read_and_write_together");
            if (mem_read_o) begin
                if (rd_q.size() == 0) fail_now("unexpected_mem_read");
                else chk("mem_read_addr", mem_addr_o, rd_q.pop_front());
            end
            if (mem_write_o) begin
                if (wr_q.size() == 0) begin
                    fail_now("unexpected_mem_write");
                end else begin
                    wr_t e;
                    e = wr_q.pop_front();
                    chk("mem_write_addr", mem_addr_o, e.addr);
                    chk("mem_write_data", mem_data_o, e.data);
                end
            end
            if (!mem_read_o && !mem_write_o) chk("mem_bus_idle_zero", mem_addr_o | mem_data_o, 32'h0);
            if (rsp_valid_o) begin
                if (rsp_q.size() == 0) begin
                    fail_now("unexpected_rsp_valid");
                end else begin
                    rsp_t r;
                    r = rsp_q.pop_front();
                    chk("rsp_err", {31'h0, rsp_err_o}, {31'h0, r.err});
                    chk("rsp_rdata", rsp_rdata_o, r.rdata);
                    chk("rsp_latency", 32'(cyc + 1 - r.acc), 32'(r.lat));
                end
            end
        end
    end

    int acc1, acc2, acc_tmp;
    logic [1:0]  rsz;
    logic [31:0] raddr;
    bit          rhold;

    initial begin
        // Reset state
        repeat (3) @(negedge clk_i);
        chk("reset_ready", {31'h0, req_ready_o}, 32'h1);
        chk("reset_rsp_valid", {31'h0, rsp_valid_o}, 32'h0);
        chk("reset_rsp_err", {31'h0, rsp_err_o}, 32'h0);
        chk("reset_rsp_rdata", rsp_rdata_o, 32'h0);
        chk("reset_mem_ctl", {30'h0, mem_read_o, mem_write_o}, 32'h0);
        chk("reset_mem_bus", mem_addr_o | mem_data_o, 32'h0);
        rst_i = 1'b1;
        @(negedge clk_i);

        // Word store/load, byte RMW store, byte/half loads with extension
        issue(1'b1, 2'd2, 1'b0, 32'h10, 32'hDEADBEEF, 1'b1, 1'b0, acc_tmp);
        repeat (3) @(negedge clk_i);
        issue(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 1'b1, 1'b0, acc_tmp);
        issue(1'b1, 2'd0, 1'b0, 32'h13, 32'h0000005A, 1'b1, 1'b0, acc_tmp);
        issue(1'b0, 2'd0, 1'b0, 32'h12, 32'h0, 1'b1, 1'b0, acc_tmp);
        issue(1'b0, 2'd0, 1'b1, 32'h12, 32'h0, 1'b1, 1'b0, acc_tmp);
        issue(1'b0, 2'd1, 1'b0, 32'h12, 32'h0, 1'b1, 1'b0, acc_tmp);

        // Rejected accesses, then confirm memory untouched
        issue(1'b1, 2'd1, 1'b0, 32'h11, 32'h1234, 1'b1, 1'b0, acc_tmp);
        issue(1'b0, 2'd2, 1'b0, 32'h80, 32'h0, 1'b1, 1'b0, acc_tmp);
        issue(1'b0, 2'd3, 1'b0, 32'h00, 32'h0, 1'b1, 1'b0, acc_tmp);
        issue(1'b1, 2'd1, 1'b0, 32'h7F, 32'h5555, 1'b1, 1'b0, acc_tmp);
        issue(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 1'b1, 1'b0, acc_tmp);

        // Reset during the READ of a sub-word store aborts it cleanly
        issue(1'b1, 2'd2, 1'b0, 32'h20, 32'h11223344, 1'b1, 1'b0, acc_tmp);
        repeat (3) @(negedge clk_i);
        rd_q.push_back(32'h20);
        issue(1'b1, 2'd1, 1'b0, 32'h20, 32'h0000ABCD, 1'b0, 1'b0, acc_tmp);
        chk("abort_in_read", {31'h0, mem_read_o}, 32'h1);
        #1 rst_i = 1'b0;
        #1;
        chk("abort_write_low", {31'h0, mem_write_o}, 32'h0);
        chk("abort_rsp_low", {31'h0, rsp_valid_o}, 32'h0);
        chk("abort_ready_high", {31'h0, req_ready_o}, 32'h1);
        @(negedge clk_i);
        @(negedge clk_i);
        chk("abort_no_write", {31'h0, mem_write_o}, 32'h0);
        rst_i = 1'b1;
        @(negedge clk_i);
        chk("abort_ready_after", {31'h0, req_ready_o}, 32'h1);
        chk("abort_word_unchanged",
            {dmem[8'h23], dmem[8'h22], dmem[8'h21], dmem[8'h20]}, ref_word(32));
        issue(1'b0, 2'd2, 1'b0, 32'h20, 32'h0, 1'b1, 1'b0, acc_tmp);

        // Back-to-back loads with valid held high
        issue(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 1'b1, 1'b1, acc1);
        issue(1'b0, 2'd0, 1'b1, 32'h13, 32'h0, 1'b1, 1'b0, acc2);
        chk("b2b_accept_gap", 32'(acc2 - acc1), 32'd3);

        // Randomized traffic
        rhold = 1'b0;
        for (int n = 0; n < 300; n++) begin
            rsz = ($urandom_range(0, 15) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
            case ($urandom_range(0, 9))
                0: raddr = $urandom;
                1: raddr = 32'(120 + $urandom_range(0, 15));
                default: raddr = 32'($urandom_range(0, 127));
            endcase
            if ($urandom_range(0, 3) != 0) begin
                if (rsz == 2'd1) raddr[0] = 1'b0;
                if (rsz == 2'd2) raddr[1:0] = 2'b00;
            end
            rhold = (n < 299) && ($urandom_range(0, 1) == 1);
            issue(1'($urandom_range(0, 1)), rsz, 1'($urandom_range(0, 1)), raddr, $urandom,
                  1'b1, rhold, acc_tmp);
            if (!rhold && $urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(negedge clk_i);
        end
        req_valid_i = 1'b0;

        // Drain
        for (int k = 0; k < 50 && (rsp_q.size() != 0 || wr_q.size() != 0 || rd_q.size() != 0); k++)
            @(negedge clk_i);
        repeat (3) @(negedge clk_i);
        chk("rsp_queue_drained", 32'(rsp_q.size()), 32'd0);
        chk("write_queue_drained", 32'(wr_q.size()), 32'd0);
        chk("read_queue_drained", 32'(rd_q.size()), 32'd0);
        for (int i = 0; i < MEM_BYTES; i++) begin
            if (dmem[i] !== ref_mem[i]) begin
                chk("final_mem_byte", {24'h0, dmem[i]}, {24'h0, ref_mem[i]});
                break;
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
